// File: rtl/delay_pkg.sv
// Shared helpers for the programmable delay blocks: width derivation and
// request clamping.
package delay_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Width of a delay select able to encode 0..max_depth inclusive.
  function automatic int dw_for(input int max_depth);
    return clog2(max_depth + 1);
  endfunction

  function automatic int clamp_delay(input int req, input int max_d);
    return (req > max_d) ? max_d : req;
  endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// Selects stage (sel-1) of the delay line as {valid, data}, or the bypass
// word when sel is zero.
module delay_tap_mux
  import delay_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 16,
  parameter int DW        = 5
) (
  input  logic [MAX_DEPTH*(WIDTH+1)-1:0] taps,
  input  logic [DW-1:0]                  sel,
  input  logic [WIDTH:0]                 bypass,
  output logic [WIDTH:0]                 tap_out
);

  logic [WIDTH:0] tap_sel_s;

  // AND-OR one-hot selection keeps the mux flat and latch-free.
  always_comb begin
    tap_sel_s = {(WIDTH+1){1'b0}};
    for (int i = 0; i < MAX_DEPTH; i++) begin
      tap_sel_s = tap_sel_s |
                  (taps[i*(WIDTH+1) +: (WIDTH+1)] & {(WIDTH+1){sel == DW'(i + 1)}});
    end
    if (sel == {DW{1'b0}}) begin
      tap_out = bypass;
    end else begin
      tap_out = tap_sel_s;
    end
  end

endmodule

// File: rtl/delay_line_prog.sv
// Programmable-depth data/valid delay line with clock enable, flush and
// run-time reconfiguration (a config change clears everything in flight).
module delay_line_prog
  import delay_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_DEPTH  = 16,
  parameter bit RESET_DATA = 1'b0,
  localparam int DW        = dw_for(MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    cfg_delay,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             pending,
  output logic             cfg_err
);

  logic [DW-1:0]                  d_s;
  logic [DW-1:0]                  cfg_q_r;
  logic                           cfg_change_s;
  logic                           clear_s;
  logic                           cfg_err_r;
  logic                           pending_s;
  logic [MAX_DEPTH-1:0]           valid_s;
  logic [WIDTH-1:0]               data_s [MAX_DEPTH];
  logic [MAX_DEPTH*(WIDTH+1)-1:0] taps_s;
  logic [WIDTH:0]                 tap_out_s;

  assign d_s          = DW'(clamp_delay(int'(cfg_delay), MAX_DEPTH));
  assign cfg_change_s = (d_s != cfg_q_r);
  assign clear_s      = flush | cfg_change_s;

  // Active depth and range error track the request on every edge, enabled or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q_r   <= {DW{1'b0}};
      cfg_err_r <= 1'b0;
    end else begin
      cfg_q_r   <= d_s;
      cfg_err_r <= (int'(cfg_delay) > MAX_DEPTH);
    end
  end

  for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in_s;
    logic             v_in_s;
    logic [WIDTH-1:0] d_r;
    logic             v_r;

    if (i == 0) begin : g_head
      assign d_in_s = in_data;
      assign v_in_s = in_valid;
    end else begin : g_link
      assign d_in_s = data_s[i-1];
      assign v_in_s = valid_s[i-1];
    end

    // Clears beat the enable so a flush also drops the word being captured.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_r <= 1'b0;
      end else if (clear_s) begin
        v_r <= 1'b0;
      end else if (en) begin
        v_r <= v_in_s;
      end else begin
        v_r <= v_r;
      end
    end

    if (RESET_DATA) begin : g_data_rst
      // Data word with reset.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          d_r <= {WIDTH{1'b0}};
        end else if (en) begin
          d_r <= d_in_s;
        end else begin
          d_r <= d_r;
        end
      end
    end else begin : g_data_norst
      // Data word without reset; qualified by the valid bit downstream.
      always_ff @(posedge clk) begin
        if (en) begin
          d_r <= d_in_s;
        end else begin
          d_r <= d_r;
        end
      end
    end

    assign valid_s[i] = v_r;
    assign data_s[i]  = d_r;
    assign taps_s[i*(WIDTH+1) +: (WIDTH+1)] = {v_r, d_r};
  end

  delay_tap_mux #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH),
    .DW        (DW)
  ) u_tap_mux (
    .taps    (taps_s),
    .sel     (cfg_q_r),
    .bypass  ({in_valid, in_data}),
    .tap_out (tap_out_s)
  );

  // Only stages inside the active depth count as in flight.
  always_comb begin
    pending_s = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      pending_s = pending_s | (valid_s[i] & (DW'(i) < cfg_q_r));
    end
  end

  assign out_valid = tap_out_s[WIDTH] & ~cfg_change_s;
  assign out_data  = tap_out_s[WIDTH-1:0];
  assign pending   = pending_s;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_delay_line_prog.sv
// Directed bench for delay_line_prog: a history-queue model checked every
// cycle, plus hand-computed pins for the key scenarios.
module tb_delay_line_prog;

  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 16;
  localparam int DW        = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic [DW-1:0]    cfg_delay;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             pending;
  logic             cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  delay_line_prog #(
    .WIDTH      (WIDTH),
    .MAX_DEPTH  (MAX_DEPTH),
    .RESET_DATA (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .cfg_delay (cfg_delay),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pending   (pending),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Model: hist[j] is the word accepted j enabled edges ago (j=0 newest).
  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t hist[$];
  int   m_cfg;
  logic m_err;

  function automatic int clamp_req(input int r);
    return (r > MAX_DEPTH) ? MAX_DEPTH : r;
  endfunction

  task automatic m_reset();
    ent_t e;
    hist.delete();
    e.v = 1'b0;
    e.d = 8'h00;
    for (int j = 0; j < MAX_DEPTH; j++) hist.push_back(e);
    m_cfg = 0;
    m_err = 1'b0;
  endtask

  task automatic m_push(input logic v, input logic [WIDTH-1:0] d);
    ent_t e;
    e.v = v;
    e.d = d;
    hist.push_front(e);
    void'(hist.pop_back());
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
    end else begin
      int dm;
      dm    = clamp_req(int'(cfg_delay));
      m_err = (int'(cfg_delay) > MAX_DEPTH);
      if (flush || dm != m_cfg) begin
        for (int j = 0; j < MAX_DEPTH; j++) hist[j].v = 1'b0;
        if (en) m_push(1'b0, in_data);
      end else if (en) begin
        m_push(in_valid, in_data);
      end
      m_cfg = dm;
    end
  end

  function automatic logic exp_valid();
    logic fwd;
    fwd = (m_cfg == 0) ? in_valid : hist[m_cfg-1].v;
    return fwd && (clamp_req(int'(cfg_delay)) == m_cfg);
  endfunction

  function automatic logic [WIDTH-1:0] exp_data();
    return (m_cfg == 0) ? in_data : hist[m_cfg-1].d;
  endfunction

  function automatic logic exp_pending();
    logic p;
    p = 1'b0;
    for (int j = 0; j < m_cfg; j++) p = p | hist[j].v;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic ev;
      ev = exp_valid();
      check("model_out_valid", {31'd0, out_valid}, {31'd0, ev});
      if (ev && out_valid) check("model_out_data", {24'd0, out_data}, {24'd0, exp_data()});
      check("model_pending", {31'd0, pending}, {31'd0, exp_pending()});
      check("model_cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
    end
  end

  task automatic step(input logic e, input logic f, input int c, input logic v,
                      input logic [WIDTH-1:0] dd);
    en        = e;
    flush     = f;
    cfg_delay = c[DW-1:0];
    in_valid  = v;
    in_data   = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0; cfg_delay = 5'd5;
    in_valid = 1'b1; in_data = 8'h11;
    m_reset();
    started = 1'b1;

    // Reset held with a non-zero delay request.
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;

    // Single word at d=5.
    step(1'b1, 1'b0, 5, 1'b0, 8'h00);
    step(1'b1, 1'b0, 5, 1'b1, 8'hA5);
    for (int j = 1; j <= 5; j++) begin
      step(1'b1, 1'b0, 5, 1'b0, 8'h00);
      if (j == 4) begin
        check("a5_out_valid", {31'd0, out_valid}, 32'd1);
        check("a5_out_data", {24'd0, out_data}, 32'h0000_00A5);
      end else begin
        check("a5_quiet", {31'd0, out_valid}, 32'd0);
      end
    end

    // Ramp at d=3 with en toggling.
    step(1'b1, 1'b0, 3, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      step((i % 2) == 0, 1'b0, 3, 1'b1, i[7:0]);
      if (i == 4 || i == 5) check("ramp_first", {23'd0, out_valid, out_data}, 32'h0000_0100);
      if (i == 6) check("ramp_second", {23'd0, out_valid, out_data}, 32'h0000_0102);
    end

    // Reconfigure 4 -> 7 mid-stream.
    step(1'b1, 1'b0, 4, 1'b1, 8'h40);
    for (int j = 0; j < 6; j++) step(1'b1, 1'b0, 4, 1'b1, 8'h41 + j[7:0]);
    en = 1'b1; flush = 1'b0; cfg_delay = 5'd7; in_valid = 1'b1; in_data = 8'h50;
    #1;
    check("chg_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b0, 7, 1'b1, 8'h60 + j[7:0]);
      if (j == 6) check("chg_first_word", {23'd0, out_valid, out_data}, 32'h0000_0160);
      if (j < 6) check("chg_no_old", {31'd0, out_valid}, 32'd0);
    end

    // Flush with four words in flight at d=6.
    step(1'b1, 1'b0, 6, 1'b0, 8'h00);
    for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 6, 1'b1, 8'h70 + j[7:0]);
    check("flush_pending_before", {31'd0, pending}, 32'd1);
    step(1'b1, 1'b1, 6, 1'b1, 8'h74);
    check("flush_pending_after", {31'd0, pending}, 32'd0);
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b0, 6, 1'b0, 8'h00);
      check("flush_no_out", {31'd0, out_valid}, 32'd0);
    end

    // Bypass at d=0, also with en=0.
    step(1'b1, 1'b0, 0, 1'b0, 8'h00);
    en = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    #1;
    check("bypass_on", {23'd0, out_valid, out_data}, 32'h0000_013C);
    in_valid = 1'b0; in_data = 8'hC3;
    #1;
    check("bypass_off", {23'd0, out_valid, out_data}, 32'h0000_00C3);
    @(posedge clk);
    #1;

    // Over-range request clamps to MAX_DEPTH and flags cfg_err.
    step(1'b1, 1'b0, MAX_DEPTH + 3, 1'b0, 8'h00);
    check("clamp_cfg_err", {31'd0, cfg_err}, 32'd1);
    step(1'b1, 1'b0, MAX_DEPTH + 3, 1'b1, 8'h99);
    for (int j = 1; j <= 16; j++) begin
      step(1'b1, 1'b0, MAX_DEPTH + 3, 1'b0, 8'h00);
      if (j == 15) check("max_depth_word", {23'd0, out_valid, out_data}, 32'h0000_0199);
    end
    step(1'b1, 1'b0, MAX_DEPTH, 1'b0, 8'h00);
    check("clamp_err_clear", {31'd0, cfg_err}, 32'd0);

    // d=1 single register, then 1 -> 0 switches to bypass.
    step(1'b1, 1'b0, 1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1, 1'b1, 8'hB1);
    check("d1_word", {23'd0, out_valid, out_data}, 32'h0000_01B1);
    step(1'b1, 1'b0, 1, 1'b0, 8'h00);
    check("d1_gone", {31'd0, out_valid}, 32'd0);
    step(1'b1, 1'b0, 0, 1'b1, 8'hC0);
    check("to_bypass", {23'd0, out_valid, out_data}, 32'h0000_01C0);

    // Asynchronous reset mid-stream.
    step(1'b1, 1'b0, 5, 1'b0, 8'h00);
    for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 5, 1'b1, 8'hD0 + j[7:0]);
    check("mid_pending", {31'd0, pending}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_pending", {31'd0, pending}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b0, 5, 1'b0, 8'h00);
      check("arst_no_stale", {31'd0, out_valid}, 32'd0);
    end

    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
